button_reader: RTL and testbench
================================

# button_reader

Input-side counterpart to the LED drivers: samples up to `NUM_BUTTONS` raw, asynchronous, bouncing push-button pins in the `CLK_12_MHZ` domain and turns them into clean levels and single-cycle press, release and long-press events. Sits directly behind the board button pins. It feeds the LED/pattern logic, which consumes events instead of raw pins.

## Interface
Parameters:
- `NUM_BUTTONS`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz); must be ≥ 2.
- `LONG_PRESS_CYCLES`, 12000000: held cycles, counted from press acceptance, that trigger `long_press` (1 s); must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, 1: 1 means a pressed button reads 0 on `btn_raw`.

Ports:
- `CLK_12_MHZ`, input, 1: sole clock.
- `RST`, input, 1: reset, asynchronous, active-high.
- `btn_raw`, input, `NUM_BUTTONS`: raw pins, asynchronous to the clock.
- `btn_level`, output, `NUM_BUTTONS`: debounced state, 1 = pressed, independent of `ACTIVE_LOW`.
- `press`, output, `NUM_BUTTONS`: 1-cycle pulse when a press is accepted.
- `release`, output, `NUM_BUTTONS`: 1-cycle pulse when a release is accepted.
- `long_press`, output, `NUM_BUTTONS`: 1-cycle pulse, at most once per press.

## Operation
- Each channel is independent. No cross-channel interaction.
- Each channel has a 2-flop synchronizer, polarity-normalized so that 1 = pressed.
- Per-channel FSM with states IDLE, DB_PRESS, PRESSED, HELD and DB_RELEASE:
  - IDLE: `btn_level`=0. A synchronized 1 goes to DB_PRESS with the counter cleared.
  - DB_PRESS: the counter increments while the input is 1. An input of 0 returns to IDLE, which counts as a bounce with no event. When the counter reaches `DEBOUNCE_CYCLES`-1, the channel goes to PRESSED, asserts `press`, sets `btn_level`=1 and clears the hold counter.
  - PRESSED: the hold counter increments each cycle. When it reaches `LONG_PRESS_CYCLES`-1, the channel asserts `long_press` and goes to HELD. An input of 0 goes to DB_RELEASE.
  - HELD: `btn_level`=1 with no further events. An input of 0 goes to DB_RELEASE.
  - DB_RELEASE: the counter increments while the input is 0. An input of 1 returns to the state the channel came from: PRESSED with its hold counter intact, or HELD. When the counter reaches `DEBOUNCE_CYCLES`-1, the channel goes to IDLE, asserts `release` and sets `btn_level`=0.
- The hold counter keeps counting during DB_RELEASE. A long-press threshold reached in DB_RELEASE fires `long_press` and makes the return state HELD.
- Counter width is `$clog2(LONG_PRESS_CYCLES)`. Counters saturate and never wrap.
- Simultaneous events:
  - `press` and `release` are never asserted together on one channel.
  - `long_press` and `release` can never coincide, because `release` requires the release debounce to complete.
  - Multiple channels may pulse in the same cycle.

## Timing
- Reset values: all outputs 0, every FSM in IDLE, counters 0, synchronizer flops at the released level.
- Asynchronous assert of `RST` takes effect immediately, even mid-debounce or mid-hold. No event is emitted on reset.
- A button held through reset release produces `press` after the normal debounce. It is not suppressed.
- Press latency is 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles from a stable pin edge to `press`/`btn_level`. Release latency is identical.
- `long_press` is asserted exactly `LONG_PRESS_CYCLES` cycles after `press`.
- All outputs are registered. There are no combinational paths from `btn_raw`.

## Structure
- Shared package `button_pkg` holds the FSM state enum (IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE) and default timing constants derived from 12 MHz.
- Sub-module `button_channel` contains one synchronizer, FSM and counters per channel. The `button_reader` top is a generate loop over `NUM_BUTTONS` plus polarity handling.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- Clean press on ch0, held for 10 cycles, then clean release -> `press` pulses 6 cycles after the edge, `btn_level`[0]=1, `release` pulses 6 cycles after the release edge, no `long_press`.
- Bounce pattern 1,0,1,0 (1 cycle each), then stable 1 -> exactly one `press`, timed from the final stable edge. Same check on release.
- Hold ch2 for 30 cycles -> `press`, then `long_press` exactly 20 cycles later, then `release`. Only one `long_press`.
- A 2-cycle release glitch during PRESSED -> no `release`, and `long_press` still fires at press+20.
- Assert `RST` mid-DB_PRESS and mid-HELD -> all outputs 0 immediately, and no event until the pin goes stable again.
- Press all 4 channels in the same cycle, with `ACTIVE_LOW`=1 and pins driven 0 -> `press`=4'b1111 in one cycle, and `btn_level`=4'b1111.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_pkg
//  Purpose  : Shared types and 12 MHz timing defaults for the button reader.
//  Revision : 1.0  initial release
// ============================================================================
package button_pkg;

  localparam int CLK_HZ                    = 12_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 100;  // 10 ms
  localparam int DEFAULT_LONG_PRESS_CYCLES = CLK_HZ;        // 1 s

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_t;

  // Debounced level is 1 in every state that follows an accepted press.
  function automatic logic is_pressed_state(input btn_state_t s);
    return (s == PRESSED) || (s == HELD) || (s == DB_RELEASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module   : button_channel
//  Purpose  : One button: 2-flop synchronizer, debounce FSM, hold counter,
//             registered level and press/release/long-press pulses.
//             Input `pin` is already polarity-normalized (1 = pressed).
//  Revision : 1.0  initial release
// ============================================================================
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int            CW      = $clog2(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0]    sync;
  logic          in_sync;
  btn_state_t    state, state_n;
  logic [CW-1:0] db_cnt, db_cnt_n, db_inc;
  logic [CW-1:0] hold_cnt, hold_cnt_n, hold_inc;
  logic          long_done, long_done_n;
  logic          long_hit;
  logic          press_n, release_n, long_n;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], pin};
  end

  assign in_sync = sync[1];

  // Saturating increments: counters never wrap.
  assign db_inc   = (db_cnt   == CNT_MAX) ? db_cnt   : db_cnt   + CW'(1);
  assign hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CW'(1);

  // Long press fires once per press, exactly LONG_PRESS_CYCLES after press.
  assign long_hit = (hold_cnt == LP_LAST) && !long_done;

  // Next-state, counter and event decode. The IDLE/PRESSED sample that
  // starts a debounce counts as the first stable cycle, so the debounce
  // completes when the incremented counter reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_n     = state;
    db_cnt_n    = db_cnt;
    hold_cnt_n  = hold_cnt;
    long_done_n = long_done;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
    case (state)
      IDLE: begin
        if (in_sync) begin
          state_n  = DB_PRESS;
          db_cnt_n = '0;
        end
      end
      DB_PRESS: begin
        if (!in_sync) begin
          state_n  = IDLE;
          db_cnt_n = '0;
        end else if (db_inc == DB_LAST) begin
          state_n     = PRESSED;
          press_n     = 1'b1;
          db_cnt_n    = '0;
          hold_cnt_n  = '0;
          long_done_n = 1'b0;
        end else begin
          db_cnt_n = db_inc;
        end
      end
      PRESSED: begin
        hold_cnt_n = hold_inc;
        if (long_hit) begin
          long_n      = 1'b1;
          long_done_n = 1'b1;
        end
        if (!in_sync) begin
          state_n  = DB_RELEASE;
          db_cnt_n = '0;
        end else if (long_hit) begin
          state_n = HELD;
        end
      end
      HELD: begin
        hold_cnt_n = hold_inc;
        if (!in_sync) begin
          state_n  = DB_RELEASE;
          db_cnt_n = '0;
        end
      end
      DB_RELEASE: begin
        hold_cnt_n = hold_inc;
        if (in_sync) begin
          // Bounce: go back where we came from, hold count untouched.
          state_n  = (long_done || long_hit) ? HELD : PRESSED;
          db_cnt_n = '0;
          if (long_hit) begin
            long_n      = 1'b1;
            long_done_n = 1'b1;
          end
        end else if (db_inc == DB_LAST) begin
          // Completed release takes priority over a coincident long press.
          state_n   = IDLE;
          release_n = 1'b1;
          db_cnt_n  = '0;
        end else begin
          db_cnt_n = db_inc;
          if (long_hit) begin
            long_n      = 1'b1;
            long_done_n = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        db_cnt_n = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      db_cnt        <= db_cnt_n;
      hold_cnt      <= hold_cnt_n;
      long_done     <= long_done_n;
      level         <= is_pressed_state(state_n);
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_reader.sv
`default_nettype none
// ============================================================================
//  Module   : button_reader
//  Purpose  : NUM_BUTTONS independent debounced button channels producing
//             clean levels and press / release / long-press pulses.
//             `release` is a reserved word, so that output is release_pulse.
//  Revision : 1.0  initial release
// ============================================================================
module button_reader
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                   CLK_12_MHZ,
  input  logic                   RST,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] press,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press
);

  logic [NUM_BUTTONS-1:0] pin_pressed;

  // Normalize polarity before synchronizing so every channel sees 1 = pressed.
  assign pin_pressed = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  generate
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      button_channel #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
      ) u_channel (
        .clk          (CLK_12_MHZ),
        .rst          (RST),
        .pin          (pin_pressed[i]),
        .level        (btn_level[i]),
        .press        (press[i]),
        .release_pulse(release_pulse[i]),
        .long_press   (long_press[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_reader
//  Purpose  : Self-checking bench for button_reader (directed + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_reader;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int LP = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] btn_level, press, release_pulse, long_press;

  always #5 clk = ~clk;

  button_reader #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1)
  ) dut (
    .CLK_12_MHZ(clk), .RST(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press(press), .release_pulse(release_pulse), .long_press(long_press)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pin history, level, run length of samples that
  // disagree with the level, and cycles elapsed since the last press.
  bit            m_d1[NB], m_d2[NB], m_lvl[NB], m_fired[NB];
  int            m_run[NB], m_since[NB];
  logic [NB-1:0] e_level, e_press, e_rel, e_long;
  int            n_press[NB], n_rel[NB], n_long[NB];

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_fired[c] = 1;
      m_run[c] = 0; m_since[c] = 0;
    end
    e_level = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  task automatic model_edge();
    bit in_v;
    e_press = '0; e_rel = '0; e_long = '0;
    for (int c = 0; c < NB; c++) begin
      in_v    = m_d2[c];          // the pin as seen two clocks ago
      m_d2[c] = m_d1[c];
      m_d1[c] = ~btn_raw[c];      // active low: 0 on the pin = pressed
      if (in_v != m_lvl[c]) m_run[c]++;
      else                  m_run[c] = 0;
      if (m_run[c] == DB) begin
        m_lvl[c] = ~m_lvl[c];
        m_run[c] = 0;
        if (m_lvl[c]) begin
          e_press[c] = 1'b1; m_since[c] = 0; m_fired[c] = 0;
        end else begin
          e_rel[c] = 1'b1;
        end
      end else if (m_lvl[c]) begin
        m_since[c]++;
        if (m_since[c] == LP && !m_fired[c]) begin
          e_long[c] = 1'b1; m_fired[c] = 1;
        end
      end
      e_level[c] = m_lvl[c];
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check("level", btn_level, e_level);
    check("press", press, e_press);
    check("release", release_pulse, e_rel);
    check("long_press", long_press, e_long);
    for (int c = 0; c < NB; c++) begin
      if (press[c])         n_press[c]++;
      if (release_pulse[c]) n_rel[c]++;
      if (long_press[c])    n_long[c]++;
    end
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  // Step until the chosen pulse (0 press, 1 release, 2 long) shows on ch;
  // n is the number of clocks taken, or `bound` on timeout.
  task automatic wait_evt(input int kind, input int ch, input int bound, output int n);
    logic [NB-1:0] v;
    n = 0;
    do begin
      step();
      n++;
      v = (kind == 0) ? press : (kind == 1) ? release_pulse : long_press;
    end while (!v[ch] && n < bound);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_level"}, btn_level, '0);
    check({tag, "_press"}, press, '0);
    check({tag, "_release"}, release_pulse, '0);
    check({tag, "_long"}, long_press, '0);
    model_reset();
  endtask

  initial begin
    int n, base;
    for (int c = 0; c < NB; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
    end
    model_reset();
    #12;
    check("reset_level", btn_level, '0);
    check("reset_press", press, '0);
    check("reset_release", release_pulse, '0);
    check("reset_long", long_press, '0);
    step(); step();
    rst = 1'b0;
    steps(3);

    // Clean press/release on ch0.
    btn_raw[0] = 1'b0;
    wait_evt(0, 0, 40, n); check_int("t1_press_latency", n, DB + 2);
    check("t1_level", btn_level, 4'b0001);
    steps(4);
    btn_raw[0] = 1'b1;
    wait_evt(1, 0, 40, n); check_int("t1_release_latency", n, DB + 2);
    steps(3);
    check_int("t1_no_long", n_long[0], 0);

    // Bounce on ch1, press then release.
    base = n_press[1];
    btn_raw[1] = 1'b0; step(); btn_raw[1] = 1'b1; step();
    btn_raw[1] = 1'b0; step(); btn_raw[1] = 1'b1; step();
    btn_raw[1] = 1'b0;
    wait_evt(0, 1, 40, n); check_int("t2_press_latency", n, DB + 2);
    steps(3);
    check_int("t2_one_press", n_press[1] - base, 1);
    base = n_rel[1];
    btn_raw[1] = 1'b1; step(); btn_raw[1] = 1'b0; step();
    btn_raw[1] = 1'b1; step(); btn_raw[1] = 1'b0; step();
    btn_raw[1] = 1'b1;
    wait_evt(1, 1, 40, n); check_int("t2_release_latency", n, DB + 2);
    steps(3);
    check_int("t2_one_release", n_rel[1] - base, 1);

    // Long hold on ch2.
    base = n_long[2];
    btn_raw[2] = 1'b0;
    wait_evt(0, 2, 40, n); check_int("t3_press_latency", n, DB + 2);
    wait_evt(2, 2, 40, n); check_int("t3_long_latency", n, LP);
    steps(4);
    btn_raw[2] = 1'b1;
    wait_evt(1, 2, 40, n); check_int("t3_release_latency", n, DB + 2);
    steps(3);
    check_int("t3_one_long", n_long[2] - base, 1);

    // 2-cycle release glitch on ch3 while PRESSED.
    base = n_rel[3];
    btn_raw[3] = 1'b0;
    wait_evt(0, 3, 40, n); check_int("t4_press_latency", n, DB + 2);
    steps(5);
    btn_raw[3] = 1'b1; step(); step();
    btn_raw[3] = 1'b0;
    wait_evt(2, 3, 40, n); check_int("t4_long_latency", n, LP - 7);
    check_int("t4_no_release", n_rel[3] - base, 0);
    btn_raw[3] = 1'b1;
    wait_evt(1, 3, 40, n); check_int("t4_release_latency", n, DB + 2);
    steps(2);

    // Reset mid-DB_PRESS; pin held through reset gives a normal press.
    btn_raw[0] = 1'b0;
    steps(4);
    async_reset_check("t5_db_press");
    steps(2);
    rst = 1'b0;
    wait_evt(0, 0, 40, n); check_int("t5_press_after_reset", n, DB + 2);
    // Reset mid-HELD; pin released during reset gives no events.
    wait_evt(2, 0, 40, n); check_int("t5_long_latency", n, LP);
    steps(3);
    base = n_press[0] + n_rel[0] + n_long[0];
    async_reset_check("t5_held");
    btn_raw[0] = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(10);
    check_int("t5_no_events", n_press[0] + n_rel[0] + n_long[0] - base, 0);

    // All four channels pressed together.
    btn_raw = '0;
    wait_evt(0, 0, 40, n); check_int("t6_press_latency", n, DB + 2);
    check("t6_press_all", press, 4'b1111);
    check("t6_level_all", btn_level, 4'b1111);
    btn_raw = '1;
    wait_evt(1, 0, 40, n);
    check("t6_release_all", release_pulse, 4'b1111);
    steps(3);

    // Random segments with bounces, long holds and occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      btn_raw = NB'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        async_reset_check("rnd_reset");
        step();
        rst = 1'b0;
      end
      steps($urandom_range(1, 28));
    end
    btn_raw = '1;
    steps(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
